// File: rtl/axis_pkt_addr_gen_pkg.sv
// Shared types and helpers for the packet address generator.
package axis_pkt_addr_gen_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BASE   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Widest tkeep the popcount helper accepts; callers zero-extend to this
  localparam int unsigned KEEP_MAX_WIDTH = 1024;
  // Wide enough to hold a count of 0..KEEP_MAX_WIDTH
  localparam int unsigned POP_WIDTH      = 11;

  // Number of set bits in a (zero-extended) tkeep vector
  function automatic logic [POP_WIDTH-1:0] keep_popcount(input logic [KEEP_MAX_WIDTH-1:0] keep);
    logic [POP_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(KEEP_MAX_WIDTH); i++) begin
      cnt = cnt + POP_WIDTH'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_pkt_addr_gen_if.sv
// AXI-Stream bundle used for both the input and output stream ports.
interface axis_pkt_addr_gen_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);

endinterface

// File: rtl/axis_pkt_skid.sv
// Two-entry skid buffer for the output stream (used with AXIS_PKT_ADDR_GEN_SKID_EN).
// in_ready_o comes only from the fill level, so there is no combinational
// path from out_ready_i back to the producer.
module axis_pkt_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push_c, pop_c;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign push_c      = in_valid_i & in_ready_o;
  assign pop_c       = out_valid_o & out_ready_i;

  // Pointer and occupancy update
  always_comb begin
    cnt_d    = cnt_q + 2'(push_c) - 2'(pop_c);
    wr_ptr_d = push_c ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_c  ? ~rd_ptr_q : rd_ptr_q;
  end

  // Occupancy and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/axis_pkt_addr_gen.sv
// Packet address generator: takes a descriptor (addr, len), publishes the
// base address to the AXI bridge, forwards stream beats until len bytes have
// been passed, swallows the rest of the packet up to tlast, then reports
// the received byte count and a length-mismatch error.
// Optional macro AXIS_PKT_ADDR_GEN_SKID_EN registers m_axis through a
// two-entry skid buffer; otherwise m_axis is a zero-latency pass-through.
module axis_pkt_addr_gen
  import axis_pkt_addr_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  axis_pkt_addr_gen_if.slave    s_axis,
  axis_pkt_addr_gen_if.master   m_axis,
  output logic [ADDR_WIDTH-1:0] axi_base_addr,
  output logic                  axi_base_addr_valid,
  output logic [LEN_WIDTH-1:0]  m_status_len,
  output logic                  m_status_error,
  output logic                  m_status_valid
);

  localparam int unsigned SUM_W = LEN_WIDTH + 1;

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;
  state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  logic                 in_stream_c;
  logic                 desc_fire_c;
  logic                 fwd_c;
  logic                 fwd_valid_c;
  logic                 fwd_ready_c;
  logic                 accept_c;
  logic [SUM_W-1:0]     pop_c;
  logic [SUM_W-1:0]     sum_c;
  logic [LEN_WIDTH-1:0] post_c;
  logic                 last_out_c;

  // Reset synchroniser: asserts immediately, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Beat classification and saturating byte count
  assign in_stream_c = (state_q == STREAM);
  assign desc_fire_c = (state_q == IDLE) & s_desc_valid;
  assign fwd_c       = (cnt_q < len_q);
  assign pop_c       = SUM_W'(keep_popcount(KEEP_MAX_WIDTH'(s_axis.tkeep)));
  assign sum_c       = {1'b0, cnt_q} + pop_c;
  assign post_c      = sum_c[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum_c[LEN_WIDTH-1:0];
  assign last_out_c  = (post_c >= len_q) | s_axis.tlast;
  assign fwd_valid_c = in_stream_c & fwd_c & s_axis.tvalid;

  // Dropped beats are always consumed; forwarded beats wait for the sink
  assign s_axis.tready = in_stream_c & (fwd_c ? fwd_ready_c : 1'b1);
  assign accept_c      = s_axis.tvalid & s_axis.tready;

`ifdef AXIS_PKT_ADDR_GEN_SKID_EN
  localparam int unsigned PAY_W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [PAY_W-1:0] skid_out_c;
  logic             skid_in_ready_c;
  logic             skid_out_valid_c;

  axis_pkt_skid #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_int_n),
    .in_data_i   ({s_axis.tdata, s_axis.tkeep, last_out_c}),
    .in_valid_i  (fwd_valid_c),
    .in_ready_o  (skid_in_ready_c),
    .out_data_o  (skid_out_c),
    .out_valid_o (skid_out_valid_c),
    .out_ready_i (m_axis.tready)
  );

  assign fwd_ready_c   = skid_in_ready_c;
  assign m_axis.tdata  = skid_out_c[PAY_W-1 -: DATA_WIDTH];
  assign m_axis.tkeep  = skid_out_c[KEEP_WIDTH:1];
  assign m_axis.tlast  = skid_out_c[0];
  assign m_axis.tvalid = skid_out_valid_c;
`else
  logic fwd_path_c;

  // Payload is zeroed whenever the beat would not be forwarded
  assign fwd_path_c    = in_stream_c & fwd_c;
  assign fwd_ready_c   = m_axis.tready;
  assign m_axis.tvalid = fwd_valid_c;
  assign m_axis.tdata  = fwd_path_c ? s_axis.tdata : '0;
  assign m_axis.tkeep  = fwd_path_c ? s_axis.tkeep : '0;
  assign m_axis.tlast  = fwd_path_c & last_out_c;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (desc_fire_c) state_d = BASE;
      BASE:    state_d = STREAM;
      STREAM:  if (accept_c && s_axis.tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    s_desc_ready        = 1'b0;
    axi_base_addr_valid = 1'b0;
    m_status_valid      = 1'b0;
    m_status_len        = '0;
    m_status_error      = 1'b0;
    case (state_q)
      IDLE:    s_desc_ready = rst_int_n;
      BASE:    axi_base_addr_valid = 1'b1;
      STREAM:  ;
      DONE: begin
        m_status_valid = 1'b1;
        m_status_len   = cnt_q;
        m_status_error = (cnt_q != len_q);
      end
      default: ;
    endcase
  end

  assign axi_base_addr = addr_q;

  // Descriptor latch and byte counter next values
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (desc_fire_c) begin
      addr_d = s_desc_addr;
      len_d  = s_desc_len;
      cnt_d  = '0;
    end
    if (in_stream_c && accept_c) begin
      cnt_d = post_c;
    end
  end

  // Descriptor and counter registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_addr_gen.sv
// Scoreboard bench for axis_pkt_addr_gen (works with or without AXIS_PKT_ADDR_GEN_SKID_EN).
`timescale 1ns/1ps
module tb_axis_pkt_addr_gen;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned AW = 34;
  localparam int unsigned LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic          err;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_desc_addr;
  logic [LW-1:0] s_desc_len;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic [AW-1:0] axi_base_addr;
  logic          axi_base_addr_valid;
  logic [LW-1:0] m_status_len;
  logic          m_status_error;
  logic          m_status_valid;

  axis_pkt_addr_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();
  axis_pkt_addr_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_axis ();

  axis_pkt_addr_gen #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_desc_addr         (s_desc_addr),
    .s_desc_len          (s_desc_len),
    .s_desc_valid        (s_desc_valid),
    .s_desc_ready        (s_desc_ready),
    .s_axis              (s_axis),
    .m_axis              (m_axis),
    .axi_base_addr       (axi_base_addr),
    .axi_base_addr_valid (axi_base_addr_valid),
    .m_status_len        (m_status_len),
    .m_status_error      (m_status_error),
    .m_status_valid      (m_status_valid)
  );

  always #5 clk = ~clk;

  localparam logic [KW-1:0] KFULL = {KW{1'b1}};
  localparam logic [KW-1:0] K36   = 64'h0000_000F_FFFF_FFFF;

  beat_t         exp_beats [$];
  logic [AW-1:0] exp_base  [$];
  stat_t         exp_stat  [$];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [DW-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_beats.push_back(b);
  endtask

  task automatic exp_status(input logic [LW-1:0] len, input logic err);
    stat_t s;
    s.len = len;
    s.err = err;
    exp_stat.push_back(s);
  endtask

  // Present a descriptor; returns at posedge+1 with the DUT in STREAM
  task automatic send_desc(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    bit ok;
    exp_base.push_back(addr);
    s_desc_addr  = addr;
    s_desc_len   = len;
    s_desc_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("desc_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 s_desc_valid = 1'b0;
    @(negedge clk);
    check("desc_ready_busy", 64'(s_desc_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat and hold it until the DUT takes it
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok;
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis.tready) begin
        ok = 1'b1;
        break;
      end
    end
    check("beat_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 s_axis.tvalid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been observed
  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_beats.size() == 0 && exp_base.size() == 0 && exp_stat.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({s_desc_ready, s_axis.tready, m_axis.tvalid, m_axis.tlast,
                              axi_base_addr_valid, m_status_valid, m_status_error}), 64'd0);
    check({tag, "_mdata"}, 64'(|m_axis.tdata), 64'd0);
    check({tag, "_mkeep"}, 64'(m_axis.tkeep), 64'd0);
    check({tag, "_base"}, 64'(axi_base_addr), 64'd0);
    check({tag, "_slen"}, 64'(m_status_len), 64'd0);
  endtask

  // Output monitor: pops and compares whenever the DUT presents something
  beat_t         mon_e, mon_g;
  logic [AW-1:0] mon_a;
  stat_t         mon_s;
  always @(negedge clk) begin
    if (m_axis.tvalid && m_axis.tready) begin
      vectors++;
      mon_g = {m_axis.tdata, m_axis.tkeep, m_axis.tlast};
      if (exp_beats.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got data[31:0]=0x%0h last=%0b, expected no beat",
                 mon_g.data[31:0], mon_g.last);
      end else begin
        mon_e = exp_beats.pop_front();
        if (mon_g !== mon_e) begin
          miscompares++;
          $display("FAIL beat: got data[31:0]=0x%0h keep=0x%0h last=%0b, expected data[31:0]=0x%0h keep=0x%0h last=%0b",
                   mon_g.data[31:0], mon_g.keep, mon_g.last, mon_e.data[31:0], mon_e.keep, mon_e.last);
        end
      end
    end
    if (axi_base_addr_valid) begin
      vectors++;
      if (exp_base.size() == 0) begin
        miscompares++;
        $display("FAIL base_unexpected: got 0x%0h, expected no pulse", axi_base_addr);
      end else begin
        mon_a = exp_base.pop_front();
        if (axi_base_addr !== mon_a) begin
          miscompares++;
          $display("FAIL base_addr: got 0x%0h, expected 0x%0h", axi_base_addr, mon_a);
        end
      end
    end
    if (m_status_valid) begin
      vectors++;
      if (exp_stat.size() == 0) begin
        miscompares++;
        $display("FAIL status_unexpected: got len=%0d err=%0b, expected no pulse", m_status_len, m_status_error);
      end else begin
        mon_s = exp_stat.pop_front();
        if (m_status_len !== mon_s.len || m_status_error !== mon_s.err) begin
          miscompares++;
          $display("FAIL status: got len=%0d err=%0b, expected len=%0d err=%0b",
                   m_status_len, m_status_error, mon_s.len, mon_s.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_desc_addr   = '0;
    s_desc_len    = '0;
    s_desc_valid  = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("idle_desc_ready", 64'(s_desc_ready), 64'd1);
    check("idle_s_tready", 64'(s_axis.tready), 64'd0);

    // len=128, two full beats -> exact length
    exp_beat(pat(1), KFULL, 1'b0);
    exp_beat(pat(2), KFULL, 1'b1);
    exp_status(16'd128, 1'b0);
    send_desc(34'h1000, 16'd128);
    send_beat(pat(1), KFULL, 1'b0);
    send_beat(pat(2), KFULL, 1'b1);
    wait_drain("drain_t1");

    // len=100, full beat then 36-byte beat
    exp_beat(pat(3), KFULL, 1'b0);
    exp_beat(pat(4), K36, 1'b1);
    exp_status(16'd100, 1'b0);
    send_desc(34'h2000, 16'd100);
    send_beat(pat(3), KFULL, 1'b0);
    send_beat(pat(4), K36, 1'b1);
    wait_drain("drain_t2");

    // len=64, three beats -> first forwarded with tlast, rest dropped
    exp_beat(pat(5), KFULL, 1'b1);
    exp_status(16'd192, 1'b1);
    send_desc(34'h2040, 16'd64);
    send_beat(pat(5), KFULL, 1'b0);
    send_beat(pat(6), KFULL, 1'b0);
    send_beat(pat(7), KFULL, 1'b1);
    wait_drain("drain_t3");

    // len=128, short packet
    exp_beat(pat(8), KFULL, 1'b1);
    exp_status(16'd64, 1'b1);
    send_desc(34'h2080, 16'd128);
    send_beat(pat(8), KFULL, 1'b1);
    wait_drain("drain_t4");

    // Zero length with one keep bit set: all dropped, error
    exp_status(16'd1, 1'b1);
    send_desc(34'h0, 16'd0);
    send_beat(pat(9), 64'h1, 1'b0);
    send_beat(pat(10), 64'h0, 1'b1);
    wait_drain("drain_t5");

    // Zero length, no keep bits: dropped, no error
    exp_status(16'd0, 1'b0);
    send_desc(34'h10, 16'd0);
    send_beat(pat(11), 64'h0, 1'b1);
    wait_drain("drain_t6");

    // Back-pressure held low for five cycles mid-packet
    for (int i = 0; i < 8; i++) exp_beat(pat(20 + i), KFULL, i == 7);
    exp_status(16'd512, 1'b0);
    send_desc(34'h3000, 16'd512);
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(pat(20 + i), KFULL, i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_axis.tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_axis.tready = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // Counter saturation at 0xFFFF
    for (int i = 0; i < 1024; i++) exp_beat(pat(100 + i), KFULL, i == 1023);
    exp_status(16'hFFFF, 1'b0);
    send_desc(34'h4_0000, 16'hFFFF);
    for (int i = 0; i < 1025; i++) send_beat(pat(100 + i), KFULL, i == 1024);
    wait_drain("drain_sat");

    // Reset asserted mid-packet: immediate clear, no status
    exp_beat(pat(50), KFULL, 1'b0);
    exp_beat(pat(51), KFULL, 1'b0);
    send_desc(34'h5000, 16'd256);
    send_beat(pat(50), KFULL, 1'b0);
    send_beat(pat(51), KFULL, 1'b0);
    repeat (3) @(posedge clk);
    check("pre_reset_busy", 64'(s_desc_ready), 64'd0);
    check("pre_reset_beats_out", 64'(exp_beats.size()), 64'd0);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("post_reset_ready", 64'(s_desc_ready), 64'd1);

    // Normal packet after reset, high address bits
    exp_beat(pat(60), KFULL, 1'b1);
    exp_status(16'd64, 1'b0);
    send_desc(34'h3_0000_0040, 16'd64);
    send_beat(pat(60), KFULL, 1'b1);
    wait_drain("drain_post_reset");

    check("left_beats", 64'(exp_beats.size()), 64'd0);
    check("left_base", 64'(exp_base.size()), 64'd0);
    check("left_status", 64'(exp_stat.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_pkt_addr_gen.md
AXIS_PKT_ADDR_GEN -- requirements
Module: axis_pkt_addr_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, stream data width in bits.
REQ-002 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 34, memory byte address width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16, descriptor byte length width.
REQ-005 The block SHALL have ports clk in 1, single clock, and rst_n in 1, asynchronous active-low reset.
REQ-006 The block SHALL have descriptor ports s_desc_addr in ADDR_WIDTH, s_desc_len in LEN_WIDTH, s_desc_valid in 1, s_desc_ready out 1.
REQ-007 The block SHALL have input stream ports s_axis_tdata in DATA_WIDTH, s_axis_tkeep in KEEP_WIDTH, s_axis_tlast in 1, s_axis_tvalid in 1, s_axis_tready out 1.
REQ-008 The block SHALL have output stream ports m_axis_tdata out DATA_WIDTH, m_axis_tkeep out KEEP_WIDTH, m_axis_tlast out 1, m_axis_tvalid out 1, m_axis_tready in 1, feeding axis_mm_bridge.
REQ-009 The block SHALL have ports axi_base_addr out ADDR_WIDTH and axi_base_addr_valid out 1, driving the bridge base-address inputs.
REQ-010 The block SHALL have status ports m_status_len out LEN_WIDTH, m_status_error out 1, m_status_valid out 1.

Function
REQ-011 The FSM SHALL have states IDLE, BASE, STREAM, DONE.
REQ-012 IDLE: s_desc_ready=1 and s_axis_tready=0; a descriptor handshake SHALL latch addr/len, clear the byte counter and move to BASE.
REQ-013 BASE: axi_base_addr SHALL hold the latched address and axi_base_addr_valid SHALL pulse high for exactly one cycle, then STREAM.
REQ-014 STREAM: every accepted beat SHALL add popcount over all KEEP_WIDTH bits of s_axis_tkeep to the byte counter; the counter SHALL saturate at 2^LEN_WIDTH-1.
REQ-015 A beat SHALL be forwarded when the pre-beat count < len, otherwise dropped: tready=1 and m_axis_tvalid=0 for that beat.
REQ-016 A forwarded beat whose post-beat count >= len, or whose s_axis_tlast=1, SHALL carry m_axis_tlast=1.
REQ-017 An accepted s_axis_tlast SHALL move STREAM to DONE; beats after the length is reached SHALL be consumed until tlast.
REQ-018 DONE: m_status_valid SHALL pulse one cycle with m_status_len = final count and m_status_error = (count != len), then IDLE.
REQ-019 A zero-length descriptor SHALL drop all beats through tlast and report error=1 if any keep bit was set.
REQ-020 s_desc_ready SHALL be 0 in BASE, STREAM and DONE; descriptors are not queued.

Reset
REQ-021 On assertion of rst_n=0, the FSM SHALL go to IDLE, and all valid/ready/status outputs, the counter, axi_base_addr and m_axis_* SHALL clear to 0, asynchronously.
REQ-022 Reset asserted mid-packet SHALL abandon the packet with no status pulse; deassertion SHALL be synchronised so the block leaves reset on a clock edge.

Configuration
REQ-023 With macro AXIS_PKT_ADDR_GEN_SKID_EN defined, m_axis_* SHALL be registered through a 2-entry skid buffer with 1-cycle latency, and s_axis_tready SHALL not depend combinationally on m_axis_tready.
REQ-024 Without AXIS_PKT_ADDR_GEN_SKID_EN, m_axis_* SHALL be combinational pass-through with 0 latency, and s_axis_tready = m_axis_tready in STREAM (1 on dropped beats).

Structure
REQ-025 Package axis_pkt_addr_gen_pkg SHALL hold the FSM state encoding and the keep-popcount function.
REQ-026 The skid buffer SHALL be sub-module axis_pkt_skid, instantiated only under AXIS_PKT_ADDR_GEN_SKID_EN.

Verification
REQ-027 Descriptor addr=0x1000, len=128, two full beats with tlast on the second -> one axi_base_addr_valid pulse at 0x1000, two beats forwarded, status len=128, error=0.
REQ-028 len=100, beats with keep=all-ones and then keep=0xF_FFFF_FFFF (36 bytes) with tlast -> status len=100, error=0.
REQ-029 len=64, three full beats with tlast on the third -> beat 1 forwarded with m_axis_tlast=1, beats 2-3 dropped, status len=192, error=1.
REQ-030 len=128, one full beat with tlast -> forwarded with tlast, status len=64, error=1.
REQ-031 m_axis_tready held low for 5 cycles mid-packet, both macro settings -> no beat lost or duplicated, data order preserved.
REQ-032 rst_n pulsed low during STREAM -> all outputs 0 immediately, no status pulse, next descriptor processed normally.
